// File: rtl/spiral_path_sequencer.sv
// spiral_path_sequencer: UP-RIGHT-DOWN-LEFT movement sequencer with debounce, rounds, abort and leg timeout
module spiral_path_sequencer #(
  parameter int NUM_ROUNDS   = 4,
  parameter int DEBOUNCE_CYC = 3,
  parameter int TIMEOUT_CYC  = 1000,
  localparam int ROUND_W     = ($clog2(NUM_ROUNDS) > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [3:0]         sensor_i,
  output logic [3:0]         movement_sel_o,
  output logic [ROUND_W-1:0] round_idx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_err_o
);
  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic [1:0] {IDLE, MOVE, DONE, FAULT} state_t;
  state_t             state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [DW-1:0]      deb_q, deb_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               hit, adv, tout, last;
  assign hit  = sensor_i[dir_q];
  assign adv  = hit && (deb_q == DW'(DEBOUNCE_CYC - 1));
  assign tout = (TIMEOUT_CYC != 0) && (tmr_q == TW'(TIMEOUT_CYC - 1));
  assign last = round_q == ROUND_W'(NUM_ROUNDS - 1);
  // state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= '0;
      round_q <= '0;
      deb_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      round_q <= round_d;
      deb_q   <= deb_d;
      tmr_q   <= tmr_d;
    end
  end
  // next state: abort beats leg advance, which beats timeout
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    round_d = round_q;
    deb_d   = deb_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = MOVE;
        dir_d   = '0;
        round_d = '0;
        deb_d   = '0;
        tmr_d   = '0;
      end
      MOVE: if (abort_i) state_d = IDLE;
      else if (adv) begin
        deb_d = '0;
        tmr_d = '0;
        dir_d = dir_q + 2'd1;
        if (dir_q == 2'd3) begin
          if (last) state_d = DONE;
          else round_d = round_q + ROUND_W'(1);
        end
      end else begin
        deb_d = hit ? deb_q + DW'(1) : '0;
        tmr_d = tmr_q + TW'(1);
        if (tout) state_d = FAULT;
      end
      DONE: state_d = IDLE;
      default: if (abort_i) state_d = IDLE;
    endcase
  end
  assign movement_sel_o = (state_q == MOVE) ? 4'b0001 << dir_q : 4'b0000;
  assign round_idx_o    = (state_q == IDLE) ? '0 : round_q;
  assign busy_o         = state_q == MOVE;
  assign done_o         = state_q == DONE;
  assign timeout_err_o  = state_q == FAULT;
endmodule

// File: tb/tb_spiral_path_sequencer.sv
// tb_spiral_path_sequencer: table vectors, directed corner sequences and random run against a leg-level model
module tb_spiral_path_sequencer;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [3:0] sensor = 0;
  logic [3:0] sel_a, sel_b;
  logic [0:0] rnd_a, rnd_b;
  logic busy_a, busy_b, done_a, done_b, err_a, err_b;
  int n_cmp = 0, n_err = 0;
  int ph[2], leg[2], hi[2], cyc[2];
  int p_r[2] = '{2, 1};
  int p_d[2] = '{3, 1};
  int p_t[2] = '{16, 4};
  always #5 clk = ~clk;
  spiral_path_sequencer #(.NUM_ROUNDS(2), .DEBOUNCE_CYC(3), .TIMEOUT_CYC(16)) u_a (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .sensor_i(sensor),
    .movement_sel_o(sel_a), .round_idx_o(rnd_a), .busy_o(busy_a), .done_o(done_a), .timeout_err_o(err_a));
  spiral_path_sequencer #(.NUM_ROUNDS(1), .DEBOUNCE_CYC(1), .TIMEOUT_CYC(4)) u_b (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .sensor_i(sensor),
    .movement_sel_o(sel_b), .round_idx_o(rnd_b), .busy_o(busy_b), .done_o(done_b), .timeout_err_o(err_b));
  typedef struct {logic st, ab; logic [3:0] sn, sel; logic rnd, bsy, dn, er;} vec_t;
  vec_t tbl[16];
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; leg[k] = 0; hi[k] = 0; cyc[k] = 0;
    end
  endtask
  // phases: 0 idle, 1 moving, 2 done, 3 fault; leg counts legs finished in this run
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit s;
      case (ph[k])
        0: if (start) begin ph[k] = 1; leg[k] = 0; hi[k] = 0; cyc[k] = 0; end
        1: if (abort) ph[k] = 0;
        else begin
          s = sensor[leg[k] % 4];
          if (s && hi[k] + 1 == p_d[k]) begin
            if (leg[k] == 4 * p_r[k] - 1) ph[k] = 2;
            else begin leg[k]++; hi[k] = 0; cyc[k] = 0; end
          end else if (p_t[k] != 0 && cyc[k] + 1 == p_t[k]) ph[k] = 3;
          else begin hi[k] = s ? hi[k] + 1 : 0; cyc[k]++; end
        end
        2: ph[k] = 0;
        default: if (abort) ph[k] = 0;
      endcase
    end
  endtask
  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] es;
      es = (ph[k] == 1) ? 8'(4'b0001 << (leg[k] % 4)) : 8'd0;
      chk($sformatf("m%0d_sel", k), k == 0 ? sel_a : sel_b, es);
      chk($sformatf("m%0d_round", k), k == 0 ? rnd_a : rnd_b, ph[k] == 0 ? 8'd0 : 8'(leg[k] / 4));
      chk($sformatf("m%0d_busy", k), k == 0 ? busy_a : busy_b, 8'(ph[k] == 1));
      chk($sformatf("m%0d_done", k), k == 0 ? done_a : done_b, 8'(ph[k] == 2));
      chk($sformatf("m%0d_err", k), k == 0 ? err_a : err_b, 8'(ph[k] == 3));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check_model();
  endtask
  task automatic do_reset();
    #2;
    rst = 1; start = 0; abort = 0; sensor = 0;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic run_leg(input int d);
    sensor = 4'b0001 << d;
    repeat (3) tick();
    sensor = 0;
  endtask
  initial begin
    int pat[6] = '{1, 1, 0, 1, 1, 1};
    tbl[0]  = '{1, 0, 4'b0000, 4'b0001, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 4'b0001, 4'b0010, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 4'b0010, 4'b0100, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 4'b0100, 4'b1000, 0, 1, 0, 0};
    tbl[4]  = '{0, 0, 4'b1000, 4'b0000, 0, 0, 1, 0};
    tbl[5]  = '{0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 4'b0001, 4'b0001, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 4'b0001, 4'b0010, 0, 1, 0, 0};
    tbl[8]  = '{0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 4'b0000, 4'b0001, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 4'b0000, 4'b0001, 0, 1, 0, 0};
    tbl[11] = '{0, 0, 4'b0000, 4'b0001, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 4'b0000, 4'b0001, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1};
    tbl[14] = '{1, 0, 4'b0000, 4'b0000, 0, 0, 0, 1};
    tbl[15] = '{0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; sensor = tbl[i].sn;
      tick();
      chk($sformatf("tbl%0d_sel", i), sel_b, tbl[i].sel);
      chk($sformatf("tbl%0d_round", i), rnd_b, tbl[i].rnd);
      chk($sformatf("tbl%0d_busy", i), busy_b, tbl[i].bsy);
      chk($sformatf("tbl%0d_done", i), done_b, tbl[i].dn);
      chk($sformatf("tbl%0d_err", i), err_b, tbl[i].er);
    end
    start = 0; abort = 0; sensor = 0;
    do_reset();
    start = 1; tick(); start = 0;
    chk("deb_enter", sel_a, 4'b0001);
    for (int j = 0; j < 6; j++) begin
      sensor = {3'b000, pat[j][0]};
      tick();
      chk($sformatf("deb_edge%0d", j + 1), sel_a, j == 5 ? 4'b0010 : 4'b0001);
    end
    sensor = 0;
    run_leg(1); run_leg(2); run_leg(3);
    chk("loop2_sel", sel_a, 4'b0001);
    chk("loop2_round", rnd_a, 1);
    run_leg(0); run_leg(1); run_leg(2); run_leg(3);
    chk("fin_done", done_a, 1);
    chk("fin_round", rnd_a, 1);
    chk("fin_sel", sel_a, 0);
    tick();
    chk("fin_idle_done", done_a, 0);
    chk("fin_idle_round", rnd_a, 0);
    do_reset();
    start = 1; tick(); start = 0;
    repeat (15) tick();
    chk("to_edge15", err_a, 0);
    tick();
    chk("to_edge16_err", err_a, 1);
    chk("to_edge16_sel", sel_a, 0);
    start = 1; tick(); start = 0;
    chk("to_start_ignored", err_a, 1);
    abort = 1; tick(); abort = 0;
    chk("to_abort_err", err_a, 0);
    chk("to_abort_busy", busy_a, 0);
    do_reset();
    start = 1; tick(); start = 0;
    sensor = 4'b0001; tick(); tick();
    abort = 1; tick(); abort = 0; sensor = 0;
    chk("ab_busy", busy_a, 0);
    chk("ab_sel", sel_a, 0);
    chk("ab_done", done_a, 0);
    tick();
    chk("ab_done_next", done_a, 0);
    do_reset();
    start = 1; tick(); start = 0;
    repeat (3) tick();
    sensor = 4'b0001; tick(); sensor = 0;
    chk("adv_vs_to_sel", sel_b, 4'b0010);
    chk("adv_vs_to_err", err_b, 0);
    do_reset();
    start = 1; tick(); start = 0;
    run_leg(0); run_leg(1); run_leg(2); run_leg(3); run_leg(0);
    chk("rst_pre_sel", sel_a, 4'b0010);
    chk("rst_pre_round", rnd_a, 1);
    #2; rst = 1; #1;
    chk("rst_async_sel", sel_a, 0);
    chk("rst_async_round", rnd_a, 0);
    chk("rst_async_busy", busy_a, 0);
    model_reset();
    check_model();
    @(posedge clk); #1; rst = 0;
    tick();
    chk("rst_stay_idle", busy_a, 0);
    start = 1; tick(); start = 0;
    chk("rst_fresh_sel", sel_a, 4'b0001);
    chk("rst_fresh_round", rnd_a, 0);
    do_reset();
    repeat (3000) begin
      start  = ($urandom % 4) == 0;
      abort  = ($urandom % 40) == 0;
      sensor = 4'($urandom | $urandom);
      if ($urandom % 400 == 0) begin
        start = 0; abort = 0; sensor = 0;
        do_reset();
      end else tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
